// File: rtl/hcmask_pkg.sv
// Shared types and constants for the hot-channel mask controller.
// Optional readback port is enabled with HCMASK_READBACK_EN (see hcmask_ctrl).
package hcmask_pkg;

    localparam int unsigned LAYER_W    = 96;
    localparam int unsigned NLAYERS    = 6;
    localparam int unsigned NCH_DEF    = LAYER_W * NLAYERS;
    localparam int unsigned WW_DEF     = 16;
    localparam int unsigned SETTLE_DEF = 8;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StDrain,
        StSwap,
        StSettle
    } hcmask_state_e;

endpackage

// File: rtl/hcmask_settle_timer.sv
// Loadable 8-bit down-counter with zero flag; paces the DRAIN and SETTLE phases.
module hcmask_settle_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    output logic       zero_o
);

    logic [7:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != 8'd0) begin
            cnt_q <= cnt_q - 8'd1;
        end
    end

    assign zero_o = (cnt_q == 8'd0);

endmodule

// File: rtl/hcmask_ctrl.sv
// Hot-channel mask controller: shadow load over 16-bit words, quiesced atomic swap.
// Define HCMASK_READBACK_EN to add the rd_addr/rd_data active-mask readback port.
module hcmask_ctrl
    import hcmask_pkg::*;
#(
    parameter int unsigned NCH    = NCH_DEF,
    parameter int unsigned WW     = WW_DEF,
    parameter int unsigned SETTLE = SETTLE_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cfg_start,
    input  logic           cfg_wr,
    input  logic [WW-1:0]  cfg_data,
    input  logic           cfg_commit,
    output logic           cfg_busy,
    output logic           cfg_done,
    output logic           cfg_err,
    output logic [5:0]     word_cnt,
    output logic [NCH-1:0] HCmask,
    output logic           input_disr
`ifdef HCMASK_READBACK_EN
    ,
    input  logic [5:0]     rd_addr,
    output logic [WW-1:0]  rd_data
`endif
);

    localparam int unsigned NWORDS    = NCH / WW;
    localparam int unsigned IDXW      = $clog2(NCH);
    localparam logic [5:0]  NWORDS_C  = 6'(NWORDS);
    localparam logic [7:0]  SETTLE_LD = 8'(SETTLE - 1);

    hcmask_state_e  state_q;
    logic [NCH-1:0] shadow_q;

    logic           wr_ok;
    logic [5:0]     cnt_after_wr;
    logic           commit_ok;
    logic           timer_load;
    logic           timer_zero;
    logic           busy_poke;
    logic [IDXW-1:0] wr_base;

    // Commit is judged against the count including any same-cycle write.
    always_comb begin
        wr_ok        = cfg_wr && (word_cnt < NWORDS_C);
        cnt_after_wr = word_cnt + {5'd0, wr_ok};
        commit_ok    = (state_q == StLoad) && !cfg_start && cfg_commit
                       && (cnt_after_wr == NWORDS_C);
        timer_load   = commit_ok || (state_q == StSwap);
        busy_poke    = cfg_start || cfg_wr || cfg_commit;
        wr_base      = IDXW'(word_cnt * WW);
    end

    hcmask_settle_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (timer_load),
        .load_val_i (SETTLE_LD),
        .zero_o     (timer_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            shadow_q   <= '1;
            HCmask     <= '1;
            input_disr <= 1'b0;
            cfg_busy   <= 1'b0;
            cfg_done   <= 1'b0;
            cfg_err    <= 1'b0;
            word_cnt   <= '0;
        end else begin
            cfg_done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (cfg_start) begin
                        state_q  <= StLoad;
                        word_cnt <= '0;
                        cfg_err  <= 1'b0;
                    end else if (cfg_wr || cfg_commit) begin
                        cfg_err <= 1'b1;
                    end
                end
                StLoad: begin
                    if (cfg_start) begin
                        word_cnt <= '0;
                        cfg_err  <= 1'b0;
                    end else begin
                        if (cfg_wr) begin
                            if (wr_ok) begin
                                shadow_q[wr_base +: WW] <= cfg_data;
                                word_cnt                <= cnt_after_wr;
                            end else begin
                                cfg_err <= 1'b1;
                            end
                        end
                        if (cfg_commit) begin
                            if (commit_ok) begin
                                state_q    <= StDrain;
                                input_disr <= 1'b1;
                                cfg_busy   <= 1'b1;
                            end else begin
                                state_q <= StIdle;
                                cfg_err <= 1'b1;
                            end
                        end
                    end
                end
                StDrain: begin
                    if (busy_poke) cfg_err <= 1'b1;
                    if (timer_zero) state_q <= StSwap;
                end
                StSwap: begin
                    if (busy_poke) cfg_err <= 1'b1;
                    HCmask  <= shadow_q;
                    state_q <= StSettle;
                end
                StSettle: begin
                    if (busy_poke) cfg_err <= 1'b1;
                    if (timer_zero) begin
                        state_q    <= StIdle;
                        input_disr <= 1'b0;
                        cfg_busy   <= 1'b0;
                        cfg_done   <= 1'b1;
                        word_cnt   <= '0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef HCMASK_READBACK_EN
    logic [IDXW-1:0] rd_base;
    assign rd_base = IDXW'(rd_addr * WW);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_addr < NWORDS_C) begin
            rd_data <= HCmask[rd_base +: WW];
        end else begin
            rd_data <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_hcmask_ctrl.sv
// Self-checking bench for hcmask_ctrl against a commit-timeline reference model.
module tb_hcmask_ctrl;

    localparam int NCH = 576;
    localparam int WW  = 16;
    localparam int NW  = 36;
    localparam int S   = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           cfg_start, cfg_wr, cfg_commit;
    logic [WW-1:0]  cfg_data;
    logic           cfg_busy, cfg_done, cfg_err, input_disr;
    logic [5:0]     word_cnt;
    logic [NCH-1:0] HCmask;
`ifdef HCMASK_READBACK_EN
    logic [5:0]     rd_addr;
    logic [WW-1:0]  rd_data;
`endif

    hcmask_ctrl #(.NCH(NCH), .WW(WW), .SETTLE(S)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_start  (cfg_start),
        .cfg_wr     (cfg_wr),
        .cfg_data   (cfg_data),
        .cfg_commit (cfg_commit),
        .cfg_busy   (cfg_busy),
        .cfg_done   (cfg_done),
        .cfg_err    (cfg_err),
        .word_cnt   (word_cnt),
        .HCmask     (HCmask),
        .input_disr (input_disr)
`ifdef HCMASK_READBACK_EN
        ,
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: m_since counts cycles since the accepted commit (0 = no commit in flight).
    logic [WW-1:0] m_shadow [NW];
    logic [WW-1:0] m_active [NW];
    logic [WW-1:0] m_rd;
    bit            m_load, m_err, m_done;
    int            m_cnt, m_since;

    task automatic m_reset();
        for (int i = 0; i < NW; i++) begin
            m_shadow[i] = '1;
            m_active[i] = '1;
        end
        m_load = 0; m_err = 0; m_done = 0; m_cnt = 0; m_since = 0; m_rd = '0;
    endtask

    task automatic m_step();
        m_done = 0;
`ifdef HCMASK_READBACK_EN
        m_rd = (int'(rd_addr) < NW) ? m_active[rd_addr] : '0;
`endif
        if (m_since != 0) begin
            if (cfg_start || cfg_wr || cfg_commit) m_err = 1;
            m_since++;
            if (m_since == S + 2) m_active = m_shadow;
            if (m_since == 2 * S + 2) begin
                m_done = 1; m_cnt = 0; m_since = 0;
            end
        end else if (!m_load) begin
            if (cfg_start) begin
                m_load = 1; m_cnt = 0; m_err = 0;
            end else if (cfg_wr || cfg_commit) begin
                m_err = 1;
            end
        end else if (cfg_start) begin
            m_cnt = 0; m_err = 0;
        end else begin
            if (cfg_wr) begin
                if (m_cnt < NW) begin
                    m_shadow[m_cnt] = cfg_data;
                    m_cnt++;
                end else begin
                    m_err = 1;
                end
            end
            if (cfg_commit) begin
                m_load = 0;
                if (m_cnt == NW) m_since = 1;
                else m_err = 1;
            end
        end
    endtask

    task automatic check(input string tag);
        logic [NCH-1:0] exp_mask;
        logic           exp_busy;
        exp_mask = '0;
        for (int i = NW - 1; i >= 0; i--) exp_mask = {exp_mask[NCH-WW-1:0], m_active[i]};
        exp_busy = (m_since != 0);
        n_cmp++;
        assert (input_disr === exp_busy) else begin
            n_fail++;
            $error("FAIL %s input_disr got %b expected %b", tag, input_disr, exp_busy);
        end
        n_cmp++;
        assert (cfg_busy === exp_busy) else begin
            n_fail++;
            $error("FAIL %s cfg_busy got %b expected %b", tag, cfg_busy, exp_busy);
        end
        n_cmp++;
        assert (cfg_done === m_done) else begin
            n_fail++;
            $error("FAIL %s cfg_done got %b expected %b", tag, cfg_done, m_done);
        end
        n_cmp++;
        assert (cfg_err === m_err) else begin
            n_fail++;
            $error("FAIL %s cfg_err got %b expected %b", tag, cfg_err, m_err);
        end
        n_cmp++;
        assert (word_cnt === 6'(m_cnt)) else begin
            n_fail++;
            $error("FAIL %s word_cnt got %0d expected %0d", tag, word_cnt, m_cnt);
        end
        n_cmp++;
        assert (HCmask === exp_mask) else begin
            n_fail++;
            $error("FAIL %s HCmask got %h expected %h", tag, HCmask, exp_mask);
        end
`ifdef HCMASK_READBACK_EN
        n_cmp++;
        assert (rd_data === m_rd) else begin
            n_fail++;
            $error("FAIL %s rd_data got %h expected %h", tag, rd_data, m_rd);
        end
`endif
    endtask

    // One clock cycle with the given inputs; model advances on the edge, outputs checked #1 later.
    task automatic cyc(input logic st, input logic wr, input logic cm,
                       input logic [WW-1:0] d, input string tag);
        cfg_start = st; cfg_wr = wr; cfg_commit = cm; cfg_data = d;
`ifdef HCMASK_READBACK_EN
        rd_addr = 6'($urandom_range(0, 40));
`endif
        @(posedge clk);
        m_step();
        #1;
        check(tag);
        cfg_start = 0; cfg_wr = 0; cfg_commit = 0;
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, '0, tag);
    endtask

    task automatic load(input int n, input logic [WW-1:0] fixed, input bit rnd, input string tag);
        cyc(1, 0, 0, '0, tag);
        for (int i = 0; i < n; i++) cyc(0, 1, 0, rnd ? WW'($urandom) : fixed, tag);
    endtask

    initial begin
        rst = 1; cfg_start = 0; cfg_wr = 0; cfg_commit = 0; cfg_data = '0;
`ifdef HCMASK_READBACK_EN
        rd_addr = '0;
`endif
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset");
        rst = 0;
        idle(2, "post_reset");

        // Async reset in the middle of SETTLE, after the swap has landed.
        load(NW, '0, 1, "rst_load");
        cyc(0, 0, 1, '0, "rst_commit");
        idle(11, "rst_wait");
        #2 rst = 1;
        #1;
        m_reset();
        check("rst_mid_settle");
        #2 rst = 0;
        idle(2, "rst_after");

        load(NW, 16'hA5A5, 0, "full_load");
        cyc(0, 0, 1, '0, "full_commit");
        idle(2 * S + 3, "full_run");

        load(NW - 1, '0, 1, "short_load");
        cyc(0, 0, 1, '0, "short_commit");
        idle(4, "short_idle");

        load(NW, '0, 1, "ovf_load");
        cyc(0, 1, 0, 16'hDEAD, "ovf_wr37");
        cyc(0, 0, 1, '0, "ovf_commit");
        idle(2 * S + 3, "ovf_run");

        // Final write and commit in one cycle; poke the busy controller at t+5.
        load(NW - 1, '0, 1, "same_load");
        cyc(0, 1, 1, 16'h1234, "same_wr_commit");
        idle(4, "same_drain");
        cyc(0, 1, 0, 16'hBEEF, "busy_wr");
        idle(2 * S, "same_run");

        load(3, '0, 1, "startwr_load");
        cyc(1, 1, 0, 16'h5555, "start_plus_wr");
        cyc(0, 1, 0, 16'h0F0F, "idle_wr");
        idle(1, "startwr_idle");
        cyc(0, 0, 1, '0, "idle_commit_after_start");
        cyc(0, 1, 0, '0, "idle_wr_err");

        for (int s = 0; s < 25; s++) begin
            int  n;
            bit  joint;
            n     = $urandom_range(NW - 2, NW + 1);
            joint = ($urandom_range(0, 1) == 1);
            cyc(1, 0, 0, '0, "rnd_start");
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) idle(1, "rnd_gap");
                if (joint && i == n - 1) cyc(0, 1, 1, WW'($urandom), "rnd_wr_commit");
                else cyc(0, 1, 0, WW'($urandom), "rnd_wr");
            end
            if (!joint) cyc(0, 0, 1, '0, "rnd_commit");
            for (int i = 0; i < 2 * S + 3; i++) begin
                if ($urandom_range(0, 7) == 0)
                    cyc(1'($urandom), 1'($urandom), 1'($urandom), WW'($urandom), "rnd_poke");
                else
                    idle(1, "rnd_run");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
